// File: rtl/stage_mem_if.sv
// -----------------------------------------------------------------------------
// stage_mem_if
//   Bundles the execute -> memory -> write-back signals of the MIPS memory
//   stage into one connection.
//   master : the side that drives the execute-stage request and receives the
//            write-back results (the pipeline / testbench).
//   slave  : the memory stage itself.
//   Request  : in_valid, outAlu, writeDataMem, MemRead, MemWrite, MemtoReg,
//              RegWrite, writeReg, memSize, memSigned
//   Response : stall, out_valid, readDataMem, aluOut_wb, MemtoReg_wb,
//              RegWrite_wb, writeReg_wb, misaligned
// -----------------------------------------------------------------------------
interface stage_mem_if;
    logic        in_valid;
    logic        stall;
    logic [31:0] outAlu;
    logic [31:0] writeDataMem;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [1:0]  memSize;
    logic        memSigned;
    logic        out_valid;
    logic [31:0] readDataMem;
    logic [31:0] aluOut_wb;
    logic        MemtoReg_wb;
    logic        RegWrite_wb;
    logic [4:0]  writeReg_wb;
    logic        misaligned;

    modport master (
        output in_valid, outAlu, writeDataMem, MemRead, MemWrite, MemtoReg,
               RegWrite, writeReg, memSize, memSigned,
        input  stall, out_valid, readDataMem, aluOut_wb, MemtoReg_wb,
               RegWrite_wb, writeReg_wb, misaligned
    );

    modport slave (
        input  in_valid, outAlu, writeDataMem, MemRead, MemWrite, MemtoReg,
               RegWrite, writeReg, memSize, memSigned,
        output stall, out_valid, readDataMem, aluOut_wb, MemtoReg_wb,
               RegWrite_wb, writeReg_wb, misaligned
    );
endinterface

// File: rtl/stage_mem.sv
// -----------------------------------------------------------------------------
// stage_mem
//   MIPS memory-access stage. Performs byte/half/word loads and stores on an
//   internal little-endian data memory and registers the results for
//   write-back. Optional wait states hold the request in WAIT and raise stall.
//   Parameters : ADDR_WIDTH  - word-address bits (depth = 2**ADDR_WIDTH words)
//                WAIT_CYCLES - extra cycles per load/store (0..15)
//   Ports      : clk   - rising-edge clock
//                reset - synchronous, active-high
//                bus   - stage_mem_if.slave (request in, write-back out)
// -----------------------------------------------------------------------------
module stage_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    stage_mem_if.slave bus
);
    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sgn;
        logic        read;
        logic        write;
        logic        memtoreg;
        logic        regwrite;
        logic [4:0]  wreg;
    } req_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic        out_valid_q, out_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        memtoreg_wb_q, memtoreg_wb_d;
    logic        regwrite_wb_q, regwrite_wb_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_out_q, alu_out_d;

    // NOTE: the memory array has no reset; a reset only abandons in-flight
    // requests, so stored contents survive it and start out as zero.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    req_t                  in_req, cur;
    logic                  mem_op, is_load, is_store, mis, access, mem_we;
    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           word, load_val, wr_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    // Datapath: decode whichever request is active (live inputs in IDLE,
    // the latched copy in WAIT).
    // NOTE: every combinational output gets a default first so no path
    // leaves a variable unassigned (which would infer a latch).
    always_comb begin
        in_req = '{addr: bus.outAlu, wdata: bus.writeDataMem, size: bus.memSize,
                   sgn: bus.memSigned, read: bus.MemRead, write: bus.MemWrite,
                   memtoreg: bus.MemtoReg, regwrite: bus.RegWrite,
                   wreg: bus.writeReg};
        cur      = (state_q == S_WAIT) ? req_q : in_req;
        mem_op   = cur.read | cur.write;
        is_store = cur.write;                 // store wins when both are set
        is_load  = cur.read & ~cur.write;
        off      = cur.addr[1:0];
        idx      = cur.addr[ADDR_WIDTH+1:2];  // upper bits ignored: wraps
        word     = mem_q[idx];
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = word[{off[1], 4'b0000} +: 16];
        wr_word  = word;
        unique case (cur.size)
            2'b00: begin
                mis      = 1'b0;
                load_val = cur.sgn ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
                wr_word[{off, 3'b000} +: 8] = cur.wdata[7:0];
            end
            2'b01: begin
                mis      = off[0];
                load_val = cur.sgn ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
                wr_word[{off[1], 4'b0000} +: 16] = cur.wdata[15:0];
            end
            default: begin
                mis      = (off != 2'b00);
                load_val = word;
                wr_word  = cur.wdata;
            end
        endcase
    end

    // FSM next state and registered write-back outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        out_valid_d   = 1'b0;
        misaligned_d  = 1'b0;
        memtoreg_wb_d = memtoreg_wb_q;
        regwrite_wb_d = regwrite_wb_q;
        write_reg_d   = write_reg_q;
        read_data_d   = read_data_q;
        alu_out_d     = alu_out_q;
        access        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (mem_op && (WAIT_CYCLES > 0)) begin
                        req_d   = in_req;
                        cnt_d   = WAIT_CNT;
                        state_d = S_WAIT;
                    end else begin
                        access = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    access  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (access) begin
            out_valid_d   = 1'b1;
            alu_out_d     = cur.addr;
            memtoreg_wb_d = cur.memtoreg;
            write_reg_d   = cur.wreg;
            misaligned_d  = mem_op & mis;
            regwrite_wb_d = cur.regwrite & ~(mem_op & mis);
            read_data_d   = (is_load && !mis) ? load_val : 32'h0;
        end
        mem_we = access & is_store & ~mis;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            req_q         <= '0;
            out_valid_q   <= 1'b0;
            misaligned_q  <= 1'b0;
            memtoreg_wb_q <= 1'b0;
            regwrite_wb_q <= 1'b0;
            write_reg_q   <= '0;
            read_data_q   <= '0;
            alu_out_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            out_valid_q   <= out_valid_d;
            misaligned_q  <= misaligned_d;
            memtoreg_wb_q <= memtoreg_wb_d;
            regwrite_wb_q <= regwrite_wb_d;
            write_reg_q   <= write_reg_d;
            read_data_q   <= read_data_d;
            alu_out_q     <= alu_out_d;
        end
    end

    // A reset on the completing edge must also cancel a pending store.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign bus.stall       = (state_q == S_WAIT);
    assign bus.out_valid   = out_valid_q;
    assign bus.readDataMem = read_data_q;
    assign bus.aluOut_wb   = alu_out_q;
    assign bus.MemtoReg_wb = memtoreg_wb_q;
    assign bus.RegWrite_wb = regwrite_wb_q;
    assign bus.writeReg_wb = write_reg_q;
    assign bus.misaligned  = misaligned_q;
endmodule
